disp_demux: RTL and testbench
=============================

# disp_demux

Receive-side decoder for the four-digit time-multiplexed seven-segment bus: an active-low digit-enable vector plus an 8-bit segment vector. It samples the bus asynchronously to its source, filters scan transitions and ghosting, and rebuilds the four per-digit segment bytes. Complete frames are presented to downstream logic, such as a display checker or logic-analyser capture, over a valid/ready handshake. It sits on the opposite end of the bus from the display multiplexer and is used for loopback verification and board-level display snooping.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples required before a bus value is accepted; legal range 2..255.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `an_in` input 4: digit enables, active low, one-out-of-four asserted; asynchronous to `clk`.
- `sseg_in` input 8: segment lines for the enabled digit; asynchronous to `clk`.
- `out3`, `out2`, `out1`, `out0` output 8 each: captured segment bytes for digits 3..0; valid while `frame_valid` is high.
- `frame_valid` output 1: a complete frame is held on `out3..out0`.
- `frame_ready` input 1: consumer accepts the frame on a clock edge where `frame_valid` and `frame_ready` are both high.
- `an_err` output 1: sticky; set when an accepted `an` value has more than one bit low.
- `overrun` output 1: sticky; set when a completed frame is dropped because the output slot is occupied.

## Operation
- **Synchronizer:** two-flop synchronizer on the 12-bit vector {`an_in`, `sseg_in`}. Reset value is {4'b1111, 8'hFF}.
- **Stability filter:** an 8-bit saturating counter and a previous-value register, driving a two-state FSM.
  - SETTLE:
    - If the synchronized vector differs from the previous value, the counter is set to 1.
    - Otherwise the counter increments.
    - When the counter reaches `STABLE_CYCLES`, the FSM issues a one-cycle accept and moves to HELD.
  - HELD: stays in HELD until the synchronized vector changes, then goes to SETTLE with the counter at 1. No further accept is issued while the vector is unchanged.
  - Reset state is SETTLE with the counter at 0.
- **Decode on accept**, by `an` value:
  - 4'b1110 → digit 0.
  - 4'b1101 → digit 1.
  - 4'b1011 → digit 2.
  - 4'b0111 → digit 3.
  - 4'b1111 (blanking gap) → ignored, no error.
  - Any other value → `an_err` set; no capture.
- **Capture:** for a decoded digit i, `cap[i]` is loaded with `sseg` and `seen[i]` is set. Re-capturing a digit already seen overwrites `cap[i]`; `seen` is unchanged.
- **Frame completion:** when `seen` equals 4'b1111, on the next edge:
  - If the slot is free, or is being accepted on that same edge: load `out0..3` from `cap`, set `frame_valid` to 1, and clear `seen`.
  - Otherwise: set `overrun`, clear `seen`, and leave `out*` and `frame_valid` unchanged. The newer frame is dropped.
- **Handshake:**
  - `frame_valid` stays high, with `out*` stable, until `frame_valid && frame_ready` on an edge. It then falls on that edge unless a new frame loads on the same edge.
  - `frame_ready` has no effect while `frame_valid` is low.
- **Frame alignment:** there is no alignment to digit 0. A frame is any four distinct digits captured in any order.
- **Reset mid-operation:** all outputs, `seen`, `cap`, the FSM and the sticky flags clear immediately. The partial frame is lost.

## Timing
- **Reset values:** `out3..out0` = 8'h00, `frame_valid` = 0, `an_err` = 0, `overrun` = 0.
- **Latency:** let E0 be the first edge at which the first synchronizer flop holds a new bus value.
  - Accept and capture occur at edge E0+`STABLE_CYCLES`.
  - `an_err` rises at that same edge.
  - `frame_valid` rises at E0+`STABLE_CYCLES`+1 when that capture completes `seen`.
- **Glitch rejection:** any bus value held for fewer than `STABLE_CYCLES` clocks is never accepted.
- **Sticky flags:** `an_err` and `overrun` clear only on reset.

## Test plan
All scenarios run with `STABLE_CYCLES`=4.
- **Basic scan:** drive `an`/`sseg` = 1110/8'hC0, 1101/8'hF9, 1011/8'hA4, 0111/8'hB0, 20 clocks each, `frame_ready` held high → one `frame_valid` pulse with `out0..3` = C0, F9, A4, B0, asserted exactly 5 clocks after the digit-3 value reaches the first synchronizer flop.
- **Glitch:** insert 1101/8'h00 for 3 clocks between full-length digits → 8'h00 is never captured; the frame still carries the long-held values.
- **Illegal enable:** hold `an` = 4'b1100 for 10 clocks → `an_err` = 1 and stays 1; no capture; a later valid scan still produces a frame.
- **Backpressure:** hold `frame_ready` = 0 and complete two full scans → first frame held unchanged, `overrun` = 1; raise `frame_ready` → `frame_valid` falls after one edge.
- **Same-edge handoff:** frame 2 completes on the edge where `frame_ready` = 1 for frame 1 → `frame_valid` stays 1, `out*` switches to frame 2, `overrun` stays 0.
- **Reset mid-frame:** assert `reset` after digits 0 and 1 are captured, then scan only digits 2 and 3 → no `frame_valid`; all outputs read 0 during and after reset.

Source files
------------

// File: rtl/disp_demux.sv
// Receive-side decoder for a four-digit multiplexed seven-segment bus.
// Filters scan glitches and rebuilds full frames behind a valid/ready slot.
module disp_demux #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an_in,
  input  logic [7:0] sseg_in,
  output logic [7:0] out3,
  output logic [7:0] out2,
  output logic [7:0] out1,
  output logic [7:0] out0,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       an_err,
  output logic       overrun
);

  localparam logic [8:0] STABLE = 9'(STABLE_CYCLES);

  typedef enum logic {
    SETTLE,
    HELD
  } state_t;

  logic [11:0]     r_sync1;
  logic [11:0]     r_sync2;
  logic [7:0]      r_cnt;
  state_t          r_state;
  logic [3:0][7:0] r_cap;
  logic [3:0][7:0] r_out;
  logic [3:0]      r_seen;
  logic            r_valid;
  logic            r_an_err;
  logic            r_overrun;

  logic            w_same;
  logic            w_acc;
  logic [3:0]      w_an;
  logic [7:0]      w_seg;
  logic [3:0]      w_hit;
  logic            w_bad;
  logic [3:0]      w_cap;
  logic            w_done;
  logic            w_take;
  logic            w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 12'hFFF;
      r_sync2 <= 12'hFFF;
    end else begin
      r_sync1 <= {an_in, sseg_in};
      r_sync2 <= r_sync1;
    end
  end

  // r_sync2 doubles as the previous-value register; change is seen on
  // its input so the count starts on the edge the new value lands.
  assign w_same = (r_sync1 == r_sync2);
  assign w_acc  = (r_state == SETTLE) && w_same &&
                  ({1'b0, r_cnt} + 9'd1 == STABLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SETTLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        SETTLE: begin
          if (!w_same) begin
            r_cnt <= 8'd1;
          end else if (w_acc) begin
            r_cnt   <= STABLE[7:0];
            r_state <= HELD;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HELD: begin
          if (!w_same) begin
            r_cnt   <= 8'd1;
            r_state <= SETTLE;
          end
        end
        default: begin
          r_cnt   <= 8'd0;
          r_state <= SETTLE;
        end
      endcase
    end
  end

  assign w_an  = r_sync2[11:8];
  assign w_seg = r_sync2[7:0];

  always_comb begin
    w_hit = 4'b0000;
    w_bad = 1'b0;
    unique case (w_an)
      4'b1110: w_hit = 4'b0001;
      4'b1101: w_hit = 4'b0010;
      4'b1011: w_hit = 4'b0100;
      4'b0111: w_hit = 4'b1000;
      4'b1111: w_hit = 4'b0000;
      default: w_bad = 1'b1;
    endcase
  end

  assign w_cap  = w_acc ? w_hit : 4'b0000;
  assign w_done = (r_seen == 4'b1111);
  assign w_take = r_valid && frame_ready;
  assign w_load = w_done && (!r_valid || w_take);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap     <= '0;
      r_out     <= '0;
      r_seen    <= 4'b0000;
      r_valid   <= 1'b0;
      r_an_err  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_cap[i]) r_cap[i] <= w_seg;
      end
      r_seen <= (w_done ? 4'b0000 : r_seen) | w_cap;
      if (w_acc && w_bad) r_an_err <= 1'b1;
      if (w_load) begin
        r_out   <= r_cap;
        r_valid <= 1'b1;
      end else begin
        if (w_done) r_overrun <= 1'b1;
        if (w_take) r_valid <= 1'b0;
      end
    end
  end

  assign out0        = r_out[0];
  assign out1        = r_out[1];
  assign out2        = r_out[2];
  assign out3        = r_out[3];
  assign frame_valid = r_valid;
  assign an_err      = r_an_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_disp_demux.sv
// Directed bench for disp_demux with STABLE_CYCLES=4.
// Inputs change on negedges; outputs are sampled on negedges.
module tb_disp_demux;

  logic       clk;
  logic       reset;
  logic [3:0] an_in;
  logic [7:0] sseg_in;
  logic [7:0] out3, out2, out1, out0;
  logic       frame_valid;
  logic       frame_ready;
  logic       an_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int vcount = 0;

  disp_demux #(.STABLE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .an_in(an_in),
    .sseg_in(sseg_in),
    .out3(out3),
    .out2(out2),
    .out1(out1),
    .out0(out0),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .an_err(an_err),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] a, input logic [7:0] s,
                       input int n);
    an_in = a;
    sseg_in = s;
    repeat (n) begin
      @(negedge clk);
      if (frame_valid === 1'b1) vcount++;
    end
  endtask

  task automatic scan(input logic [31:0] f);
    drive(4'b1110, f[7:0], 20);
    drive(4'b1101, f[15:8], 20);
    drive(4'b1011, f[23:16], 20);
    drive(4'b0111, f[31:24], 20);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    an_in = 4'hF;
    sseg_in = 8'hFF;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out3, out2, out1, out0} !== 32'h0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=0", {out3, out2, out1, out0});
    end
    total++;
    if ({frame_valid, an_err, overrun} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000",
               {frame_valid, an_err, overrun});
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if ({frame_valid, an_err, overrun} !== 3'b000) begin
      bad++;
      $display("FAIL idle_flags got=%b exp=000",
               {frame_valid, an_err, overrun});
    end
  endtask

  task automatic test_basic_scan;
    frame_ready = 1'b1;
    vcount = 0;
    drive(4'b1110, 8'hC0, 20);
    drive(4'b1101, 8'hF9, 20);
    drive(4'b1011, 8'hA4, 20);
    total++;
    if (vcount != 0) begin
      bad++;
      $display("FAIL basic_early got=%0d exp=0", vcount);
    end
    drive(4'b0111, 8'hB0, 5);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_e4 got=%b exp=0", frame_valid);
    end
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_e5 got=%b exp=1", frame_valid);
    end
    total++;
    if ({out3, out2, out1, out0} !== 32'hB0A4F9C0) begin
      bad++;
      $display("FAIL basic_data got=%h exp=B0A4F9C0",
               {out3, out2, out1, out0});
    end
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_drop got=%b exp=0", frame_valid);
    end
    vcount = 0;
    drive(4'b0111, 8'hB0, 13);
    total++;
    if (vcount != 0) begin
      bad++;
      $display("FAIL basic_pulses got=%0d exp=0", vcount);
    end
  endtask

  task automatic test_glitch;
    frame_ready = 1'b0;
    drive(4'b1110, 8'h11, 20);
    drive(4'b1111, 8'hFF, 10);
    drive(4'b1101, 8'h22, 20);
    drive(4'b1101, 8'h00, 3);
    drive(4'b1011, 8'h33, 20);
    drive(4'b0111, 8'h44, 20);
    total++;
    if (frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL glitch_valid got=%b exp=1", frame_valid);
    end
    total++;
    if ({out3, out2, out1, out0} !== 32'h44332211) begin
      bad++;
      $display("FAIL glitch_data got=%h exp=44332211",
               {out3, out2, out1, out0});
    end
    total++;
    if ({an_err, overrun} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_flags got=%b exp=00", {an_err, overrun});
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_take got=%b exp=0", frame_valid);
    end
  endtask

  task automatic test_illegal;
    frame_ready = 1'b0;
    drive(4'b1110, 8'hAA, 20);
    drive(4'b1101, 8'hBB, 20);
    drive(4'b1100, 8'h55, 4);
    total++;
    if (an_err !== 1'b0) begin
      bad++;
      $display("FAIL ill_early got=%b exp=0", an_err);
    end
    @(negedge clk);
    total++;
    if (an_err !== 1'b1) begin
      bad++;
      $display("FAIL ill_set got=%b exp=1", an_err);
    end
    drive(4'b1100, 8'h55, 5);
    drive(4'b1011, 8'hCC, 20);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL ill_noframe got=%b exp=0", frame_valid);
    end
    drive(4'b0111, 8'hDD, 20);
    total++;
    if ({frame_valid, an_err} !== 2'b11) begin
      bad++;
      $display("FAIL ill_after got=%b exp=11", {frame_valid, an_err});
    end
    total++;
    if ({out3, out2, out1, out0} !== 32'hDDCCBBAA) begin
      bad++;
      $display("FAIL ill_data got=%h exp=DDCCBBAA",
               {out3, out2, out1, out0});
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    frame_ready = 1'b0;
    scan(32'h04030201);
    total++;
    if ({frame_valid, overrun} !== 2'b10) begin
      bad++;
      $display("FAIL bp_first got=%b exp=10", {frame_valid, overrun});
    end
    scan(32'h08070605);
    total++;
    if ({frame_valid, overrun, an_err} !== 3'b111) begin
      bad++;
      $display("FAIL bp_over got=%b exp=111",
               {frame_valid, overrun, an_err});
    end
    total++;
    if ({out3, out2, out1, out0} !== 32'h04030201) begin
      bad++;
      $display("FAIL bp_held got=%h exp=04030201",
               {out3, out2, out1, out0});
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got=%b exp=0", frame_valid);
    end
  endtask

  task automatic test_back_to_back;
    test_reset;
    frame_ready = 1'b0;
    scan(32'h14131211);
    drive(4'b1110, 8'h21, 20);
    drive(4'b1101, 8'h22, 20);
    drive(4'b1011, 8'h23, 20);
    drive(4'b0111, 8'h24, 5);
    total++;
    if ({out3, out2, out1, out0} !== 32'h14131211 || frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pre got=%h/%b exp=14131211/1",
               {out3, out2, out1, out0}, frame_valid);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({frame_valid, overrun} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_flags got=%b exp=10", {frame_valid, overrun});
    end
    total++;
    if ({out3, out2, out1, out0} !== 32'h24232221) begin
      bad++;
      $display("FAIL b2b_data got=%h exp=24232221",
               {out3, out2, out1, out0});
    end
    @(negedge clk);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%b exp=0", frame_valid);
    end
  endtask

  task automatic test_reset_mid;
    frame_ready = 1'b1;
    drive(4'b1110, 8'h31, 20);
    drive(4'b1101, 8'h32, 20);
    an_in = 4'hF;
    sseg_in = 8'hFF;
    reset = 1'b1;
    #1;
    total++;
    if ({out3, out2, out1, out0, frame_valid} !== 33'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=0",
               {out3, out2, out1, out0, frame_valid});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    drive(4'b1011, 8'h33, 20);
    drive(4'b0111, 8'h34, 20);
    total++;
    if (vcount != 0) begin
      bad++;
      $display("FAIL mid_noframe got=%0d exp=0", vcount);
    end
    total++;
    if ({out3, out2, out1, out0, frame_valid, an_err, overrun} !== 35'h0) begin
      bad++;
      $display("FAIL mid_after got=%h exp=0",
               {out3, out2, out1, out0, frame_valid, an_err, overrun});
    end
  endtask

  initial begin
    reset = 1'b1;
    an_in = 4'hF;
    sseg_in = 8'hFF;
    frame_ready = 1'b0;
    test_reset;
    test_basic_scan;
    test_glitch;
    test_illegal;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
